// File: rtl/signed_bcd_seg7_seq.sv
// Sequential binary (signed or unsigned) to multi-digit 7-segment converter.
// A shift-add-3 engine produces BCD; displays are registered and change only on done.
module signed_bcd_seg7_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    val,
    input  logic                blank_lz,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [6:0]          seg7_neg_sign,
    output logic [7*DIGITS-1:0] seg7_digits
);
    // Decimal digits needed to hold 2^w-1, so the BCD register never truncates.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    localparam int DEC_N = dec_digits(WIDTH);
    localparam int BCD_N = (DEC_N > DIGITS) ? DEC_N : DIGITS;
    localparam int BCD_W = 4 * BCD_N;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic                 neg_q, neg_d;
    logic                 blz_q, blz_d;
    logic                 ovf_q, ovf_d, ovf_c;
    logic [6:0]           sign_q, sign_d;
    logic [7*DIGITS-1:0]  dig_q, dig_d, dig_c;
    logic                 done_q, done_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < BCD_N; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Display decode walks from the top digit so blanking stops at the first non-zero.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        ovf_c = (bcd_q >> (4 * DIGITS)) != '0;
        dig_c = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
            if (ovf_c)                           dig_c[7*k +: 7] = SEG_MINUS;
            else if (blz_q && !seen && k != 0)   dig_c[7*k +: 7] = SEG_BLANK;
            else                                 dig_c[7*k +: 7] = seg_code(bcd_q[4*k +: 4]);
        end
    end

    // NOTE: every variable gets its hold value before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        blz_d   = blz_q;
        ovf_d   = ovf_q;
        sign_d  = sign_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle refuses start so a held request cannot retrigger at once.
                if (start && !done_q) begin
                    neg_d   = SIGNED && val[WIDTH-1];
                    mag_d   = neg_d ? (~val + WIDTH'(1)) : val;
                    blz_d   = blank_lz;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) state_d = LOAD;
            end
            LOAD: begin
                ovf_d   = ovf_c;
                sign_d  = neg_q ? SEG_MINUS : SEG_BLANK;
                dig_d   = dig_c;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            blz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            sign_q  <= SEG_BLANK;
            dig_q   <= {DIGITS{SEG_BLANK}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            blz_q   <= blz_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign seg7_neg_sign = sign_q;
    assign seg7_digits   = dig_q;

endmodule

// File: tb/tb_signed_bcd_seg7_seq.sv
// Self-checking bench: three configurations against an arithmetic decimal reference model.
`timescale 1ns/1ps
module tb_signed_bcd_seg7_seq;
    localparam int NU = 3;
    localparam int W_T [NU] = '{8, 8, 16};
    localparam int D_T [NU] = '{3, 2, 5};
    localparam bit S_T [NU] = '{1'b1, 1'b0, 1'b1};
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [NU];
    logic [31:0] val_s   [NU];
    logic        blz_s   [NU];
    logic        busy_s  [NU];
    logic        done_s  [NU];
    logic        ovf_s   [NU];
    logic [6:0]  sign_s  [NU];
    logic [69:0] dig_s   [NU];
    logic [20:0] dig_a;
    logic [13:0] dig_b;
    logic [34:0] dig_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
    logic [6:0]  sign_a, sign_b, sign_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    signed_bcd_seg7_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .val(val_s[0][7:0]), .blank_lz(blz_s[0]),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .seg7_neg_sign(sign_a), .seg7_digits(dig_a));
    signed_bcd_seg7_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .val(val_s[1][7:0]), .blank_lz(blz_s[1]),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .seg7_neg_sign(sign_b), .seg7_digits(dig_b));
    signed_bcd_seg7_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_c (
        .clk(clk), .rst(rst), .start(start_s[2]), .val(val_s[2][15:0]), .blank_lz(blz_s[2]),
        .busy(busy_c), .done(done_c), .overflow(ovf_c), .seg7_neg_sign(sign_c), .seg7_digits(dig_c));

    assign busy_s[0] = busy_a;  assign busy_s[1] = busy_b;  assign busy_s[2] = busy_c;
    assign done_s[0] = done_a;  assign done_s[1] = done_b;  assign done_s[2] = done_c;
    assign ovf_s[0]  = ovf_a;   assign ovf_s[1]  = ovf_b;   assign ovf_s[2]  = ovf_c;
    assign sign_s[0] = sign_a;  assign sign_s[1] = sign_b;  assign sign_s[2] = sign_c;
    assign dig_s[0]  = 70'(dig_a);
    assign dig_s[1]  = 70'(dig_b);
    assign dig_s[2]  = 70'(dig_c);

    // Reference: plain integer magnitude, digits by division, blanking as "value < 10^k".
    function automatic logic [77:0] model(input int u, input logic [31:0] v, input logic b);
        longint unsigned m, lim, p;
        logic neg, ovf;
        logic [69:0] digs;
        logic [6:0] s;
        m   = 64'(v) & ((64'd1 << W_T[u]) - 64'd1);
        neg = S_T[u] && m[W_T[u]-1];
        if (neg) m = (64'd1 << W_T[u]) - m;
        lim = 1;
        for (int k = 0; k < D_T[u]; k++) lim = lim * 10;
        ovf  = (m >= lim);
        digs = '0;
        p    = 1;
        for (int k = 0; k < D_T[u]; k++) begin
            if (ovf)                       s = MINUS;
            else if (b && k > 0 && m < p)  s = BLANK;
            else                           s = seg_tab[int'((m / p) % 64'd10)];
            digs[7*k +: 7] = s;
            p = p * 10;
        end
        return {ovf, neg ? MINUS : BLANK, digs};
    endfunction

    function automatic logic [69:0] all_blank(input int u);
        logic [69:0] r;
        r = '0;
        for (int k = 0; k < 7 * D_T[u]; k++) r[k] = 1'b1;
        return r;
    endfunction

    // One conversion: lat = negedges after the accepting edge until done (-1 on timeout).
    task automatic run_conv(input int u, input logic [31:0] v, input logic b,
                            output int lat, output bit stable, output bit busy_ok);
        logic [77:0] snap;
        lat = -1; stable = 1'b1; busy_ok = 1'b1;
        @(negedge clk);
        snap = {ovf_s[u], sign_s[u], dig_s[u]};
        start_s[u] = 1'b1; val_s[u] = v; blz_s[u] = b;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start_s[u] = 1'b0;
            val_s[u] = $urandom;
            blz_s[u] = 1'($urandom);
            if (done_s[u]) begin
                lat = k;
                if (busy_s[u]) busy_ok = 1'b0;
                break;
            end
            if ({ovf_s[u], sign_s[u], dig_s[u]} !== snap) stable = 1'b0;
            if (!busy_s[u]) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            checks++;
            if ({busy_s[u], done_s[u], ovf_s[u], sign_s[u]} !== {3'b000, BLANK}) begin
                errors++;
                $display("FAIL reset_ctrl_u%0d: got %b expected %b", u,
                         {busy_s[u], done_s[u], ovf_s[u], sign_s[u]}, {3'b000, BLANK});
            end
            checks++;
            if (dig_s[u] !== all_blank(u)) begin
                errors++;
                $display("FAIL reset_digits_u%0d: got %h expected %h", u, dig_s[u], all_blank(u));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; bit st, bo;
        run_conv(0, 32'd123, 1'b0, lat, st, bo);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", lat); end
        checks++;
        if ({ovf_s[0], sign_s[0]} !== {1'b0, BLANK}) begin
            errors++; $display("FAIL basic_sign: got %b expected %b", {ovf_s[0], sign_s[0]}, {1'b0, BLANK});
        end
        checks++;
        if (dig_s[0][20:0] !== {7'b1111001, 7'b0100100, 7'b0110000}) begin
            errors++; $display("FAIL basic_digits: got %b expected 111100101001000110000", dig_s[0][20:0]);
        end
        checks++;
        if (!bo) begin errors++; $display("FAIL basic_busy: got window error expected busy through LOAD only"); end
    endtask

    task automatic test_boundaries();
        logic [7:0]  tv [3] = '{8'h80, 8'hFF, 8'h00};
        logic        tb [3] = '{1'b0, 1'b1, 1'b1};
        logic [6:0]  ts [3] = '{MINUS, MINUS, BLANK};
        logic [20:0] td [3] = '{{7'b1111001, 7'b0100100, 7'b0000000},
                                {BLANK, BLANK, 7'b1111001},
                                {BLANK, BLANK, 7'b1000000}};
        int lat; bit st, bo;
        for (int i = 0; i < 3; i++) begin
            run_conv(0, 32'(tv[i]), tb[i], lat, st, bo);
            checks++;
            if (lat !== 10) begin errors++; $display("FAIL bound_latency_%h: got %0d expected 10", tv[i], lat); end
            checks++;
            if (!st) begin errors++; $display("FAIL bound_hold_%h: got early change expected stable outputs", tv[i]); end
            checks++;
            if ({ovf_s[0], sign_s[0]} !== {1'b0, ts[i]}) begin
                errors++; $display("FAIL bound_sign_%h: got %b expected %b", tv[i], {ovf_s[0], sign_s[0]}, {1'b0, ts[i]});
            end
            checks++;
            if (dig_s[0][20:0] !== td[i]) begin
                errors++; $display("FAIL bound_digits_%h: got %b expected %b", tv[i], dig_s[0][20:0], td[i]);
            end
        end
    endtask

    task automatic test_random(input int u, input int n);
        int lat; bit st, bo;
        logic [31:0] v;
        logic b;
        logic [77:0] exp_v;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            b = 1'($urandom_range(0, 1));
            exp_v = model(u, v, b);
            run_conv(u, v, b, lat, st, bo);
            checks++;
            if (lat !== W_T[u] + 2) begin
                errors++; $display("FAIL rand_latency_u%0d: got %0d expected %0d", u, lat, W_T[u] + 2);
            end
            checks++;
            if ({ovf_s[u], sign_s[u], dig_s[u]} !== exp_v) begin
                errors++; $display("FAIL rand_value_u%0d v=%h blz=%b: got %h expected %h", u, v, b,
                                   {ovf_s[u], sign_s[u], dig_s[u]}, exp_v);
            end
            checks++;
            if (!st || !bo) begin
                errors++; $display("FAIL rand_hold_u%0d: got stable=%b busy_ok=%b expected 1 1", u, st, bo);
            end
        end
    endtask

    task automatic test_busy_ignored();
        int dones = 0;
        @(negedge clk);
        start_s[0] = 1'b1; val_s[0] = 32'd7; blz_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        start_s[0] = 1'b1; val_s[0] = 32'd45;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done_s[0]) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL busy_ignored_dones: got %0d expected 1", dones); end
        checks++;
        if ({busy_s[0], sign_s[0], dig_s[0][20:0]} !== {1'b0, BLANK, 7'b1000000, 7'b1000000, 7'b1111000}) begin
            errors++; $display("FAIL busy_ignored_value: got %b expected 0 %b 100000010000001111000",
                               {busy_s[0], sign_s[0], dig_s[0][20:0]}, BLANK);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [77:0] exp_v;
        @(negedge clk);
        start_s[0] = 1'b1; val_s[0] = 32'd200; blz_s[0] = 1'b0;
        for (k = 1; k <= 40 && !done_s[0]; k++) @(negedge clk);
        checks++;
        if (!done_s[0] || busy_s[0]) begin
            errors++; $display("FAIL b2b_first_done: got done=%b busy=%b expected 1 0", done_s[0], busy_s[0]);
        end
        val_s[0] = 32'd201;
        @(negedge clk);
        checks++;
        if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_start: got busy=%b expected 0", busy_s[0]); end
        @(negedge clk);
        start_s[0] = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b1) begin errors++; $display("FAIL b2b_next_accept: got busy=%b expected 1", busy_s[0]); end
        for (k = 1; k <= 40 && !done_s[0]; k++) @(negedge clk);
        exp_v = model(0, 32'd201, 1'b0);
        checks++;
        if (k !== 10 || {ovf_s[0], sign_s[0], dig_s[0]} !== exp_v) begin
            errors++; $display("FAIL b2b_second: got lat=%0d val=%h expected lat=10 val=%h", k,
                               {ovf_s[0], sign_s[0], dig_s[0]}, exp_v);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        @(negedge clk);
        start_s[0] = 1'b1; val_s[0] = 32'd99; blz_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_s[0], done_s[0], ovf_s[0], sign_s[0], dig_s[0][20:0]} !== {3'b000, BLANK, {3{BLANK}}}) begin
            errors++; $display("FAIL abort_reset_values: got %b expected all idle and blank",
                               {busy_s[0], done_s[0], ovf_s[0], sign_s[0], dig_s[0][20:0]});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_s[0] || busy_s[0]) dones++;
        end
        checks++;
        if (dones !== 0 || dig_s[0][20:0] !== {3{BLANK}}) begin
            errors++; $display("FAIL abort_no_done: got activity=%0d digits=%b expected 0 and blank", dones, dig_s[0][20:0]);
        end
    endtask

    task automatic test_unsigned();
        int lat; bit st, bo;
        run_conv(1, 32'd255, 1'b0, lat, st, bo);
        checks++;
        if ({lat == 10, ovf_s[1], sign_s[1], dig_s[1][13:0]} !== {2'b11, BLANK, MINUS, MINUS}) begin
            errors++; $display("FAIL unsigned_255: got lat=%0d %b expected lat=10 1 %b %b %b", lat,
                               {ovf_s[1], sign_s[1], dig_s[1][13:0]}, BLANK, MINUS, MINUS);
        end
        run_conv(1, 32'd99, 1'b0, lat, st, bo);
        checks++;
        if ({ovf_s[1], sign_s[1], dig_s[1][13:0]} !== {1'b0, BLANK, 7'b0010000, 7'b0010000}) begin
            errors++; $display("FAIL unsigned_99: got %b expected 0 %b 00100000010000",
                               {ovf_s[1], sign_s[1], dig_s[1][13:0]}, BLANK);
        end
    endtask

    task automatic test_wide();
        int lat; bit st, bo;
        run_conv(2, 32'h8000, 1'b0, lat, st, bo);
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL wide_latency: got %0d expected 18", lat); end
        checks++;
        if ({ovf_s[2], sign_s[2], dig_s[2][34:0]} !==
            {1'b0, MINUS, 7'b0110000, 7'b0100100, 7'b1111000, 7'b0000010, 7'b0000000}) begin
            errors++; $display("FAIL wide_value: got %b expected 0 minus 3 2 7 6 8",
                               {ovf_s[2], sign_s[2], dig_s[2][34:0]});
        end
    endtask

    initial begin
        for (int i = 0; i < NU; i++) begin
            start_s[i] = 1'b0; val_s[i] = '0; blz_s[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_boundaries();
        test_random(0, 24);
        test_busy_ignored();
        test_back_to_back();
        test_reset_abort();
        test_unsigned();
        test_random(1, 12);
        test_wide();
        test_random(2, 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
